// File: rtl/abertura_comporta_ctrl_pkg.sv
// Shared encodings for the dispense controller; state codes share the gate UC
// numbering space so dbEstado can be read side by side with the gate UC debug bus.
package abertura_comporta_ctrl_pkg;

    localparam int unsigned PESO_W_DEF = 12;

    typedef enum logic [3:0] {
        ST_INICIAL = 4'd0,
        ST_AGUARDA = 4'd1,
        ST_ABRINDO = 4'd2,
        ST_FECHA   = 4'd3,
        ST_FIM     = 4'd4,
        ST_ERRO    = 4'd5
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'hF;

    // Debug code for a state; any code outside the legal set reads as DB_INVALIDO.
    function automatic logic [3:0] db_code(input estado_t e);
        logic [3:0] v;
        case (e)
            ST_INICIAL: v = 4'd0;
            ST_AGUARDA: v = 4'd1;
            ST_ABRINDO: v = 4'd2;
            ST_FECHA:   v = 4'd3;
            ST_FIM:     v = 4'd4;
            ST_ERRO:    v = 4'd5;
            default:    v = DB_INVALIDO;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/abertura_comporta_ctrl_contador_timeout.sv
// Saturating watchdog counter with synchronous clear/enable and a terminal-count
// flag raised one count before saturation.
module contador_timeout #(
    parameter int unsigned LIMITE = 50_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CW = $clog2(LIMITE + 1);

    logic [CW-1:0] r_count;

    // Count register: clear dominates enable, and the count holds once it hits LIMITE.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= {CW{1'b0}};
        end else if (i_clear) begin
            r_count <= {CW{1'b0}};
        end else if (i_enable && (r_count != CW'(LIMITE))) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_terminal = (r_count == CW'(LIMITE - 1));

endmodule

// File: rtl/abertura_comporta_ctrl.sv
// Dispense controller: holds the target weight, keeps the gate commanded open
// until DEBOUNCE_N consecutive samples reach it, and aborts when samples stop.
module abertura_comporta_ctrl
    import abertura_comporta_ctrl_pkg::*;
#(
    parameter int unsigned PESO_W         = PESO_W_DEF,
    parameter int unsigned DEBOUNCE_N     = 4,
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_carregaPesoMax,
    input  logic [PESO_W-1:0] i_pesoMaxIn,
    input  logic              i_iniciar,
    input  logic              i_cancelar,
    input  logic [PESO_W-1:0] i_medidaPeso,
    input  logic              i_medidaValida,
    output logic              o_abrirComporta,
    output logic              o_pesoMaxIgualZero,
    output logic              o_pronto,
    output logic              o_erroTimeout,
    output logic [3:0]        o_dbEstado
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);

    estado_t           r_state;
    estado_t           w_state_next;
    logic [PESO_W-1:0] r_peso_max;
    logic [PESO_W-1:0] w_peso_max_next;
    logic [CNT_W-1:0]  r_cnt_acima;
    logic [CNT_W-1:0]  w_cnt_acima_next;
    logic [CNT_W-1:0]  w_acima_inc;
    logic              w_peso_atingido;
    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_terminal;

    assign w_peso_atingido = (i_medidaPeso >= r_peso_max);
    assign w_acima_inc     = (r_cnt_acima == CNT_W'(DEBOUNCE_N)) ? r_cnt_acima
                                                                 : r_cnt_acima + CNT_W'(1);

    contador_timeout #(
        .LIMITE     (TIMEOUT_CICLOS)
    ) u_watchdog (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (w_wd_clear),
        .i_enable   (w_wd_enable),
        .o_terminal (w_wd_terminal)
    );

    // State, target and debounce registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_INICIAL;
            r_peso_max  <= {PESO_W{1'b0}};
            r_cnt_acima <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_next;
            r_peso_max  <= w_peso_max_next;
            r_cnt_acima <= w_cnt_acima_next;
        end
    end

    // Next state; cancelar outranks a sample, which outranks watchdog expiry.
    always_comb begin
        w_state_next     = r_state;
        w_peso_max_next  = r_peso_max;
        w_cnt_acima_next = {CNT_W{1'b0}};
        w_wd_clear       = 1'b1;
        w_wd_enable      = 1'b0;
        case (r_state)
            ST_INICIAL: begin
                if (i_carregaPesoMax) begin
                    w_peso_max_next = i_pesoMaxIn;
                end else begin
                    w_peso_max_next = r_peso_max;
                end
                if (i_iniciar && (r_peso_max != {PESO_W{1'b0}})) begin
                    w_state_next = ST_AGUARDA;
                end else begin
                    w_state_next = ST_INICIAL;
                end
            end
            ST_AGUARDA: begin
                w_wd_enable = 1'b1;
                w_wd_clear  = i_medidaValida;
                if (i_cancelar) begin
                    w_state_next = ST_INICIAL;
                end else if (i_medidaValida) begin
                    w_state_next = w_peso_atingido ? ST_FIM : ST_ABRINDO;
                end else if (w_wd_terminal) begin
                    w_state_next = ST_ERRO;
                end else begin
                    w_state_next = ST_AGUARDA;
                end
            end
            ST_ABRINDO: begin
                w_wd_enable      = 1'b1;
                w_wd_clear       = i_medidaValida;
                w_cnt_acima_next = r_cnt_acima;
                if (i_cancelar) begin
                    w_state_next     = ST_INICIAL;
                    w_cnt_acima_next = {CNT_W{1'b0}};
                end else if (i_medidaValida) begin
                    if (!w_peso_atingido) begin
                        w_cnt_acima_next = {CNT_W{1'b0}};
                        w_state_next     = ST_ABRINDO;
                    end else if (w_acima_inc == CNT_W'(DEBOUNCE_N)) begin
                        w_cnt_acima_next = {CNT_W{1'b0}};
                        w_state_next     = ST_FECHA;
                    end else begin
                        w_cnt_acima_next = w_acima_inc;
                        w_state_next     = ST_ABRINDO;
                    end
                end else if (w_wd_terminal) begin
                    w_state_next = ST_ERRO;
                end else begin
                    w_state_next = ST_ABRINDO;
                end
            end
            ST_FECHA: begin
                w_state_next = ST_FIM;
            end
            ST_FIM: begin
                w_state_next = ST_INICIAL;
            end
            ST_ERRO: begin
                if (i_cancelar) begin
                    w_state_next = ST_INICIAL;
                end else begin
                    w_state_next = ST_ERRO;
                end
            end
            default: begin
                w_state_next = ST_INICIAL;
            end
        endcase
    end

    // Moore output decode straight from the state and target registers.
    always_comb begin
        o_abrirComporta    = 1'b0;
        o_pronto           = 1'b0;
        o_erroTimeout      = 1'b0;
        o_pesoMaxIgualZero = (r_peso_max == {PESO_W{1'b0}});
        o_dbEstado         = db_code(r_state);
        case (r_state)
            ST_ABRINDO: o_abrirComporta = 1'b1;
            ST_FIM:     o_pronto        = 1'b1;
            ST_ERRO:    o_erroTimeout   = 1'b1;
            default: begin
                o_abrirComporta = 1'b0;
                o_pronto        = 1'b0;
                o_erroTimeout   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_abertura_comporta_ctrl.sv
// Bench for abertura_comporta_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a timeline-level reference model.
module tb_abertura_comporta_ctrl;

    localparam int unsigned PW = 12;
    localparam int unsigned N  = 4;
    localparam int unsigned T  = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [PW-1:0] pin;
    logic          ini;
    logic          canc;
    logic [PW-1:0] med;
    logic          val;
    logic          abrir, pmz, pronto, erro;
    logic [3:0]    db;

    int n_testes = 0;
    int n_falhas = 0;

    // Reference model: phase number, target, consecutive-hit run, idle cycles since ref.
    int m_fase   = 0;
    int m_peso   = 0;
    int m_seq    = 0;
    int m_ocioso = 0;

    abertura_comporta_ctrl #(
        .PESO_W             (PW),
        .DEBOUNCE_N         (N),
        .TIMEOUT_CICLOS     (T)
    ) dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_carregaPesoMax   (load),
        .i_pesoMaxIn        (pin),
        .i_iniciar          (ini),
        .i_cancelar         (canc),
        .i_medidaPeso       (med),
        .i_medidaValida     (val),
        .o_abrirComporta    (abrir),
        .o_pesoMaxIgualZero (pmz),
        .o_pronto           (pronto),
        .o_erroTimeout      (erro),
        .o_dbEstado         (db)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0h esperado=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic modelo_passo();
        int np;
        np = m_fase;
        if (rst) begin
            m_fase = 0; m_peso = 0; m_seq = 0; m_ocioso = 0;
            return;
        end
        case (m_fase)
            0: begin
                if (ini && m_peso != 0) np = 1;
                if (load) m_peso = int'(pin);
            end
            1, 2: begin
                if (canc) np = 0;
                else if (val) begin
                    m_ocioso = 0;
                    if (m_fase == 1) np = (int'(med) >= m_peso) ? 4 : 2;
                    else if (int'(med) >= m_peso) begin
                        m_seq++;
                        if (m_seq == N) np = 3;
                    end else m_seq = 0;
                end else if (m_ocioso == T - 1) np = 5;
                else m_ocioso++;
            end
            3: np = 4;
            4: np = 0;
            5: if (canc) np = 0;
            default: np = 0;
        endcase
        if (np != m_fase) begin
            m_seq = 0; m_ocioso = 0;
        end
        m_fase = np;
    endtask

    function automatic logic [7:0] esperado();
        logic [3:0] f;
        f = 4'(m_fase);
        return {f, (m_fase == 2), (m_peso == 0), (m_fase == 4), (m_fase == 5)};
    endfunction

    task automatic ciclo();
        @(posedge clk);
        modelo_passo();
        #1;
        verifica("saidas", {24'd0, db, abrir, pmz, pronto, erro}, {24'd0, esperado()});
    endtask

    task automatic ocioso();
        rst = 1'b0; load = 1'b0; ini = 1'b0; canc = 1'b0; val = 1'b0;
    endtask

    task automatic amostra(input int v);
        val = 1'b1; med = PW'(v);
        ciclo();
        val = 1'b0;
    endtask

    task automatic reinicia();
        ocioso(); rst = 1'b1;
        ciclo();
        rst = 1'b0;
    endtask

    task automatic parte(input int peso);
        load = 1'b1; pin = PW'(peso);
        ciclo();
        load = 1'b0; ini = 1'b1;
        ciclo();
        ini = 1'b0;
    endtask

    initial begin
        ocioso(); pin = '0; med = '0;
        reinicia();
        verifica("rst_abrir", {31'd0, abrir}, 32'd0);
        verifica("rst_pronto", {31'd0, pronto}, 32'd0);
        verifica("rst_erro", {31'd0, erro}, 32'd0);
        verifica("rst_pmz", {31'd0, pmz}, 32'd1);
        verifica("rst_db", {28'd0, db}, 32'd0);

        // Start with zero target is ignored.
        ini = 1'b1;
        repeat (3) ciclo();
        ini = 1'b0;
        verifica("zero_db", {28'd0, db}, 32'd0);

        // Normal dispense.
        parte(100);
        verifica("aguarda_db", {28'd0, db}, 32'd1);
        amostra(40);
        verifica("abre_apos_40", {31'd0, abrir}, 32'd1);
        amostra(80); amostra(100); amostra(100); amostra(100);
        verifica("ainda_aberto", {31'd0, abrir}, 32'd1);
        amostra(100);
        verifica("fecha_4o_100", {31'd0, abrir}, 32'd0);
        ciclo();
        verifica("pronto_pulso", {31'd0, pronto}, 32'd1);
        ciclo();
        verifica("pronto_unico", {31'd0, pronto}, 32'd0);

        // Debounce restart.
        ini = 1'b1; ciclo(); ini = 1'b0;
        amostra(40);
        amostra(100); amostra(100); amostra(90);
        amostra(100); amostra(100); amostra(100);
        verifica("db_reinicia", {31'd0, abrir}, 32'd1);
        amostra(100);
        verifica("db_fecha", {28'd0, db}, 32'd3);
        repeat (2) ciclo();

        // First sample already above target.
        ini = 1'b1; ciclo(); ini = 1'b0;
        amostra(150);
        verifica("direto_fim", {31'd0, pronto}, 32'd1);
        ciclo();

        // Watchdog: tie-break in the expiry cycle, then a real timeout.
        ini = 1'b1; ciclo(); ini = 1'b0;
        amostra(40);
        repeat (T - 1) ciclo();
        verifica("wd_antes", {28'd0, db}, 32'd2);
        amostra(40);
        verifica("wd_empate", {28'd0, db}, 32'd2);
        repeat (T) ciclo();
        verifica("wd_erro", {31'd0, erro}, 32'd1);
        verifica("wd_fechado", {31'd0, abrir}, 32'd0);
        ini = 1'b1; ciclo(); ini = 1'b0;
        verifica("erro_ignora_ini", {28'd0, db}, 32'd5);
        canc = 1'b1; ciclo(); canc = 1'b0;
        verifica("cancela_erro", {28'd0, db}, 32'd0);

        // Cancel together with a sample, and frozen target during ABRINDO.
        ini = 1'b1; ciclo(); ini = 1'b0;
        amostra(40);
        load = 1'b1; pin = PW'(55); ciclo(); load = 1'b0;
        canc = 1'b1; amostra(100); canc = 1'b0;
        verifica("cancela_com_amostra", {28'd0, db}, 32'd0);
        ini = 1'b1; ciclo(); ini = 1'b0;
        amostra(60);
        verifica("peso_congelado", {28'd0, db}, 32'd2);
        amostra(12'hFFF); amostra(12'hFFF); amostra(12'hFFF); amostra(12'hFFF);
        verifica("saturado_fecha", {28'd0, db}, 32'd3);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            int r;
            int lacuna;
            rst  = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 3);
            pin  = (r == 0) ? PW'(0) : (r == 1) ? PW'($urandom_range(1, 8)) : PW'($urandom);
            ini  = ($urandom_range(0, 7) == 0);
            canc = ($urandom_range(0, 59) == 0);
            lacuna = ((c / 100) % 4 == 3);
            val  = lacuna ? 1'b0 : ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 5);
            case (r)
                0: med = PW'(0);
                1: med = PW'(m_peso - 1);
                2: med = PW'(m_peso);
                3: med = PW'(m_peso + 1);
                4: med = 12'hFFF;
                default: med = PW'($urandom);
            endcase
            ciclo();
        end

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
